// File: rtl/shift_pkg.sv
// Shared constants and types for the multi-cycle shift sequencer.
package shift_pkg;

    localparam int SHIFT_W = 16;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

endpackage

// File: rtl/shifter.sv
// Single-step combinational shifter: applies one bit of the selected shift op.
module shifter
    import shift_pkg::*;
#(
    parameter int W = SHIFT_W
) (
    input  logic [W-1:0] in,
    input  logic [1:0]   shift,
    output logic [W-1:0] sout
);

    always_comb begin
        sout = in;
        case (shift)
            SH_LSL:  sout = {in[W-2:0], 1'b0};
            SH_LSR:  sout = {1'b0, in[W-1:1]};
            SH_ASR:  sout = {in[W-1], in[W-1:1]};
            default: sout = in;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Shift-by-N sequencer: iterates the one-bit shifter once per clock, with
// valid/ready handshakes on both the request and the result side.
module shift_seq
    import shift_pkg::*;
#(
    parameter int W     = SHIFT_W,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             in_ready,
    input  logic [W-1:0]     in,
    input  logic [1:0]       shift,
    input  logic [AMT_W-1:0] amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     sout
);

    state_t           state;
    logic [1:0]       op;
    logic [AMT_W-1:0] cnt;
    logic [W-1:0]     step;

    shifter #(.W(W)) u_shifter (
        .in    (sout),
        .shift (op),
        .sout  (step)
    );

    // Handshake flags are pure state decodes, so no comb path from start/out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sout  <= '0;
            op    <= SH_NONE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sout <= in;
                        op   <= shift;
                        cnt  <= amount;
                        // Nothing to iterate: result is the operand itself.
                        if (shift == SH_NONE || amount == '0)
                            state <= DONE;
                        else
                            state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sout <= step;
                    cnt  <= cnt - 1'b1;
                    if (cnt == AMT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: expected results queued at request time.
module tb_shift_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_ready;
    logic [15:0] d_in;
    logic [1:0]  sh;
    logic [3:0]  amt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sout;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] exp_q[$];
    int          lat_q[$];

    shift_seq #(.W(16), .AMT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_ready  (in_ready),
        .in        (d_in),
        .shift     (sh),
        .amount    (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sout      (sout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] op, input int n);
        logic [15:0] r;
        r = d;
        if (op != 2'b00)
            for (int i = 0; i < n; i++)
                case (op)
                    2'b01:   r = r << 1;
                    2'b10:   r = r >> 1;
                    default: r = $signed(r) >>> 1;
                endcase
        return r;
    endfunction

    // Issue one request, optionally jam start with junk while busy, hold off
    // out_ready for 'hold' cycles, then consume the result.
    task automatic run_req(input logic [15:0] d, input logic [1:0] op, input logic [3:0] n,
                           input bit noise, input int hold);
        int          lat;
        bit          got;
        logic [15:0] e;
        int          el;
        exp_q.push_back(model(d, op, int'(n)));
        lat_q.push_back((op != 2'b00 && n != 0) ? int'(n) : 1);
        @(negedge clk);
        chk("idle_rdy", {31'd0, in_ready}, 32'd1);
        start = 1'b1; d_in = d; sh = op; amt = n;
        @(posedge clk); #1;
        start = noise;
        if (noise) begin d_in = ~d; sh = ~op; amt = ~n; end
        lat = 0; got = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            chk("busy_rdy", {31'd0, in_ready}, 32'd0);
            if (out_valid) got = 1;
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        if (!got) begin
            chk("timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", lat, el);
        chk("sout", {16'd0, sout}, {16'd0, e});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sout", {16'd0, sout}, {16'd0, e});
            chk("bp_rdy", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("retain", {16'd0, sout}, {16'd0, e});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; d_in = '0; sh = '0; amt = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("rst_sout", {16'd0, sout}, 32'd0);
        @(negedge clk) reset = 1'b0;

        run_req(16'hF0CF, 2'b01, 4'd4, 0, 0);
        run_req(16'hF0CF, 2'b10, 4'd3, 0, 0);
        run_req(16'hF0CF, 2'b11, 4'd3, 0, 0);
        run_req(16'h8000, 2'b11, 4'd15, 0, 0);
        run_req(16'h7FFF, 2'b11, 4'd15, 0, 0);
        run_req(16'h0001, 2'b01, 4'd15, 0, 0);
        run_req(16'hF0CF, 2'b01, 4'd0, 0, 0);
        run_req(16'hF0CF, 2'b00, 4'd9, 0, 0);
        run_req(16'h1234, 2'b10, 4'd5, 1, 5);
        run_req(16'hA5C3, 2'b11, 4'd0, 1, 5);
        run_req(16'h00F1, 2'b01, 4'd7, 0, 0);
        for (int k = 0; k < 6; k++)
            run_req(16'($urandom), 2'($urandom), 4'($urandom_range(0, 15)), k[0], k);

        // Reset mid-SHIFT, between clock edges.
        @(negedge clk);
        start = 1'b1; d_in = 16'h0F0F; sh = 2'b01; amt = 4'd10;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_rdy", {31'd0, in_ready}, 32'd1);
        chk("arst_sout", {16'd0, sout}, 32'd0);
        @(negedge clk) reset = 1'b0;
        run_req(16'h0003, 2'b01, 4'd2, 0, 0);
        chk("final_sout", {16'd0, sout}, 32'h000C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle shift sequencer for the datapath's shift stage.
- Accepts an operand, a 2-bit shift op and a 4-bit shift amount over a valid/ready handshake.
- Drives the existing single-step combinational shifter once per clock until the amount is used up, then presents the result over a valid/ready handshake.
- Acts as the initiator/controller around the one-bit shifter, which is the responder: it turns single-bit shifts into shift-by-N.

Parameters:
- W, 16, operand/result width in bits.
- AMT_W, 4, shift-amount width; the maximum amount is 2**AMT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- in  input  W  operand.
- shift  input  2  op: 00 none, 01 left by 1 per step, 10 logical right (MSB<-0), 11 arithmetic right (MSB<-MSB).
- amount  input  AMT_W  number of steps.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sout  output  W  result register.

Behaviour:
- One clock; reset is asynchronous and active-high (clk, reset).
- Reset values: state=IDLE, in_ready=1, out_valid=0, sout=0, internal count=0, latched op=00.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Acceptance is start&&in_ready at a rising edge.
  - On acceptance: sout<=in, op<=shift, cnt<=amount.
  - If shift==00 or amount==0, go to DONE; otherwise go to SHIFT.
  - Without acceptance, stay in IDLE and hold sout.
- SHIFT:
  - Each edge: sout<=shifter(sout, op), cnt<=cnt-1.
  - When cnt==1 at the edge, go to DONE.
  - Exactly `amount` single-bit steps are applied.
  - start is ignored.
- DONE:
  - out_valid=1; sout holds stable.
  - On out_valid&&out_ready at an edge, go to IDLE.
  - Holds indefinitely under backpressure.
- Latency from the acceptance edge to out_valid visible: amount cycles when op!=00 and amount>=1; otherwise 1 cycle.
- Throughput: one request per (latency+1) cycles at best.
  - The result handshake and the next request acceptance never share an edge, because in_ready is low in DONE.
- Width rules:
  - Left shifts fill the LSB with 0.
  - Bits shifted out are discarded; there is no carry or flag output.
  - Amounts up to 15 are legal: LSL/LSR by 15 leaves at most one original bit; ASR by 15 gives all copies of the sign bit.
- in_ready and out_valid are decoded directly from the state register (Moore); there are no combinational paths from start or out_ready.
- After out_valid drops, sout retains its last value until the next acceptance.
- Reset asserted in any state, including mid-SHIFT or in DONE under backpressure: immediate return to reset values. The in-flight request is dropped and no partial result is presented.
- Inputs in, shift and amount are sampled only on the acceptance edge; changes while busy have no effect.

Decomposition:
- Package shift_pkg holds:
  - shift-op constants: SH_NONE=2'b00, SH_LSL=2'b01, SH_LSR=2'b10, SH_ASR=2'b11;
  - state enum typedef {IDLE, SHIFT, DONE};
  - W default constant.
- Sub-module: instantiate the existing `shifter` (ports in, shift, sout) as the single-step combinational unit. It is fed by the sout register and the latched op, and its output is registered back into sout.
- The FSM, counter and result register live in shift_seq.

Test Plan:
- Reset, then in=16'hF0CF, shift=01, amount=4, start pulse → out_valid rises exactly 4 cycles after acceptance, sout=16'h0CF0, in_ready=0 throughout.
- in=16'hF0CF, shift=10, amount=3 → sout=16'h1E19 after 3 cycles; then shift=11, amount=3 on the same operand → sout=16'hFE19.
- ASR amount=15 on 16'h8000 → 16'hFFFF; on 16'h7FFF → 16'h0000. LSL amount=15 on 16'h0001 → 16'h8000.
- Amount 0 and op none:
  - amount=0, shift=01, in=16'hF0CF → out_valid 1 cycle after acceptance, sout=16'hF0CF;
  - shift=00, amount=9 → same 1-cycle latency and unchanged operand.
- Backpressure and input isolation:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid and sout stable, in_ready=0.
  - start pulses with new data during SHIFT/DONE are ignored.
  - Release out_ready → IDLE next cycle with in_ready=1, and the next request is processed correctly.
- Assert reset 2 cycles into a 10-step LSL, asynchronously between edges → out_valid=0, in_ready=1, sout=0 immediately. After release, a new request (16'h0003, LSL, 2) yields 16'h000C.
